// File: rtl/spike_pkg.sv
// Shared definitions for the spike stream reader: readout FSM states and
// width helpers used to size the buffer address and row id.
package spike_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    function automatic int addr_width(input int max_timesteps, input int rows);
        return $clog2(max_timesteps * rows);
    endfunction

    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/spike_stream_reader_if.sv
// Spike vector output stream: valid/ready handshake carrying the vector
// together with its row, timestep and end-of-readout marker.
interface spike_stream_reader_if #(
    parameter int PE_COUNT = 128,
    parameter int ROW_W    = 8,
    parameter int TS_W     = 16
);
    logic                m_valid;
    logic                m_ready;
    logic [PE_COUNT-1:0] m_data;
    logic [ROW_W-1:0]    m_row_id;
    logic [TS_W-1:0]     m_timestep;
    logic                m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_row_id,
        output m_timestep,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_row_id,
        input  m_timestep,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/spike_stream_fifo.sv
// Two-entry output FIFO; the head entry drives the stream directly so the
// presented beat stays stable until it is popped.
module spike_stream_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         pop_eff;

    assign pop_eff = pop && (count_reg != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr_reg] <= push_data;
                wr_ptr_reg      <= ~wr_ptr_reg;
            end
            if (pop_eff) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop_eff})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign valid = (count_reg != 2'd0);
    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/spike_stream_reader.sv
// Reads a timestep range out of the spike buffer and streams one vector per row.
// Optional: SPIKE_STREAM_SKIP_ZERO_EN drops all-zero vectors except the final one.
module spike_stream_reader
    import spike_pkg::*;
#(
    parameter int ROWS           = 256,
    parameter int PE_COUNT       = 128,
    parameter int TIMESTEP_WIDTH = 16,
    parameter int MAX_TIMESTEPS  = 256,
    localparam int AW            = addr_width(MAX_TIMESTEPS, ROWS),
    localparam int RW            = row_width(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [TIMESTEP_WIDTH-1:0] ts_first,
    input  logic [TIMESTEP_WIDTH-1:0] ts_count,
    output logic                      busy,
    output logic                      done,
    output logic                      range_err,
    output logic                      rd_en,
    output logic [AW-1:0]             rd_addr,
    input  logic [PE_COUNT-1:0]       rd_data,
    spike_stream_reader_if.master     m,
    output logic [AW:0]               beat_count
);
    localparam int FW = 1 + TIMESTEP_WIDTH + RW + PE_COUNT;

    state_t                    state;
    logic [AW-1:0]             addr_reg;
    logic [AW-1:0]             final_addr_reg;
    logic [RW-1:0]             row_reg;
    logic [TIMESTEP_WIDTH-1:0] ts_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic                      range_err_reg;
    logic [AW:0]               beat_count_reg;

    // Tag of the read issued last cycle; its data is on rd_data now.
    logic                      inflight_reg;
    logic [RW-1:0]             tag_row_reg;
    logic [TIMESTEP_WIDTH-1:0] tag_ts_reg;
    logic                      tag_last_reg;

    logic [TIMESTEP_WIDTH:0]   ts_end;
    logic [AW-1:0]             first_addr;
    logic [AW-1:0]             final_addr;
    logic                      read_go;
    logic                      last_issue;
    logic                      push;
    logic                      pop;
    logic                      fifo_valid;
    logic [1:0]                fifo_count;
    logic [FW-1:0]             fifo_in;
    logic [FW-1:0]             fifo_head;

    assign ts_end     = {1'b0, ts_first} + {1'b0, ts_count};
    assign first_addr = AW'(32'(ts_first) * 32'(ROWS));
    assign final_addr = AW'(32'(ts_end) * 32'(ROWS) - 32'd1);
    assign last_issue = (addr_reg == final_addr_reg);
    assign pop        = fifo_valid && m.m_ready;

    // Occupancy is taken after this cycle's pop so a draining sink keeps
    // the read pipeline full; this is what allows one beat per cycle.
    assign read_go = (state == READ) &&
                     (({1'b0, fifo_count} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop}));

`ifdef SPIKE_STREAM_SKIP_ZERO_EN
    assign push = inflight_reg && ((|rd_data) || tag_last_reg);
`else
    assign push = inflight_reg;
`endif

    assign fifo_in = {tag_last_reg, tag_ts_reg, tag_row_reg, rd_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_reg       <= '0;
            final_addr_reg <= '0;
            row_reg        <= '0;
            ts_reg         <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            range_err_reg  <= 1'b0;
            beat_count_reg <= '0;
            inflight_reg   <= 1'b0;
            tag_row_reg    <= '0;
            tag_ts_reg     <= '0;
            tag_last_reg   <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            inflight_reg <= read_go;
            if (read_go) begin
                tag_row_reg  <= row_reg;
                tag_ts_reg   <= ts_reg;
                tag_last_reg <= last_issue;
            end
            if (pop && (beat_count_reg != {(AW+1){1'b1}})) begin
                beat_count_reg <= beat_count_reg + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (ts_count == '0) begin
                            beat_count_reg <= '0;
                            done_reg       <= 1'b1;
                            state          <= DONE;
                        end else if (32'(ts_end) > MAX_TIMESTEPS) begin
                            range_err_reg <= 1'b1;
                            done_reg      <= 1'b1;
                            state         <= DONE;
                        end else begin
                            range_err_reg  <= 1'b0;
                            beat_count_reg <= '0;
                            addr_reg       <= first_addr;
                            final_addr_reg <= final_addr;
                            row_reg        <= '0;
                            ts_reg         <= ts_first;
                            busy_reg       <= 1'b1;
                            state          <= READ;
                        end
                    end
                end
                READ: begin
                    if (read_go) begin
                        if (last_issue) begin
                            state <= DRAIN;
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                            if (row_reg == RW'(ROWS - 1)) begin
                                row_reg <= '0;
                                ts_reg  <= ts_reg + 1'b1;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if ((fifo_count == 2'd0) && !inflight_reg) begin
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    spike_stream_fifo #(
        .W(FW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(fifo_in),
        .pop      (pop),
        .valid    (fifo_valid),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign range_err    = range_err_reg;
    assign rd_en        = read_go;
    assign rd_addr      = addr_reg;
    assign beat_count   = beat_count_reg;
    assign m.m_valid    = fifo_valid;
    assign m.m_data     = fifo_head[PE_COUNT-1:0];
    assign m.m_row_id   = fifo_head[PE_COUNT +: RW];
    assign m.m_timestep = fifo_head[PE_COUNT+RW +: TIMESTEP_WIDTH];
    assign m.m_last     = fifo_head[FW-1];

endmodule

// File: doc/spike_stream_reader.md
SPIKE_STREAM_READER -- requirements
Module: spike_stream_reader

Interface
REQ-001 Parameter ROWS, default 256: rows per timestep in the spike buffer.
REQ-002 Parameter PE_COUNT, default 128: spike vector width.
REQ-003 Parameter TIMESTEP_WIDTH, default 16: timestep field width.
REQ-004 Parameter MAX_TIMESTEPS, default 256: buffer depth in timesteps; AW = $clog2(MAX_TIMESTEPS*ROWS).
REQ-005 The block SHALL have a single clock and an asynchronous, active-low reset, with ports in this order:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a readout.
- ts_first  in  TIMESTEP_WIDTH  first timestep to read.
- ts_count  in  TIMESTEP_WIDTH  number of timesteps to read.
- busy  out  1  readout in progress.
- done  out  1  one-cycle completion pulse.
- range_err  out  1  sticky; the last start request was out of range.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  AW  buffer read address.
- rd_data  in  PE_COUNT  buffer data, valid exactly 1 cycle after rd_en.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  stream sink ready.
- m_data  out  PE_COUNT  spike vector.
- m_row_id  out  $clog2(ROWS)  row of the beat.
- m_timestep  out  TIMESTEP_WIDTH  timestep of the beat.
- m_last  out  1  final beat of the readout.
- beat_count  out  AW+1  beats transferred in the current or last readout.

Function
REQ-006 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-007 IDLE: start with ts_count==0 SHALL go to DONE and emit no beats.
REQ-008 IDLE: start with ts_first+ts_count > MAX_TIMESTEPS (computed TIMESTEP_WIDTH+1 wide) SHALL set range_err, go to DONE, and emit no beats.
REQ-009 IDLE: any other start SHALL clear range_err and beat_count and go to READ.
REQ-010 start SHALL be ignored in every state except IDLE.
REQ-011 READ: addresses SHALL be issued in order: timestep outer loop, row inner loop; rd_addr = ts*ROWS + row.
REQ-012 READ SHALL assert rd_en only while (output FIFO occupancy + reads in flight) < 2.
REQ-013 Returned rd_data, tagged with its row and timestep, SHALL enter a 2-entry FIFO that drives m_*.
REQ-014 After the final address is issued, the FSM SHALL go to DRAIN; DRAIN SHALL go to DONE once the FIFO is empty and no read is in flight.
REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE; busy=1 in READ and DRAIN only.
REQ-016 A beat SHALL transfer when m_valid && m_ready; m_* SHALL hold stable while m_valid && !m_ready.
REQ-017 beat_count SHALL increment on each transfer and SHALL NOT wrap.
REQ-018 m_last SHALL be 1 only on the beat from the final address.
REQ-019 At full throughput (m_ready held 1), the block SHALL sustain 1 beat/cycle; the first m_valid SHALL occur 2 cycles after the cycle start is sampled.

Reset
REQ-020 On rst_n=0 the FSM SHALL go to IDLE, the FIFO SHALL empty and in-flight reads SHALL be discarded.
REQ-021 On rst_n=0 all outputs SHALL go to 0: busy, done, range_err, rd_en, rd_addr, m_valid, m_data, m_row_id, m_timestep, m_last, beat_count.
REQ-022 Reset asserted mid-readout SHALL abort the readout without a done pulse.

Configuration
REQ-023 Macro SPIKE_STREAM_SKIP_ZERO_EN, when defined, SHALL drop all-zero rd_data vectors before FIFO entry, except the final address, which is always emitted so m_last occurs.
REQ-024 Without SPIKE_STREAM_SKIP_ZERO_EN, every address SHALL produce exactly one beat.

Structure
REQ-025 A shared package spike_pkg SHALL hold the FSM state enum and the address-width helper constant.
REQ-026 The 2-entry output FIFO SHALL be a sub-module, spike_stream_fifo.

Verification
REQ-027 ROWS=4, ts_first=2, ts_count=3, m_ready=1: 12 beats on addresses 8..19 in order, 1 beat/cycle, m_last on row 3 of ts 4, beat_count=12, one done pulse.
REQ-028 Same run with m_ready toggling 1/0 every cycle: identical 12-beat sequence, no loss or duplication, m_* stable across stalls.
REQ-029 ts_first=250, ts_count=10 with MAX_TIMESTEPS=256: range_err=1, done pulse, no rd_en, no beats.
REQ-030 ts_count=0: done pulse 1 cycle after start, no beats, beat_count=0.
REQ-031 With SPIKE_STREAM_SKIP_ZERO_EN, buffer holds nonzero only at addr 9, read range 8..19: 2 beats (addr 9, then addr 19 with m_last).
REQ-032 rst_n pulsed low at beat 5 of 12: all outputs 0, no done; a new start then completes a full readout normally.
